// File: rtl/bcd_adder.sv
// ---------------------------------------------------------------------------
// bcd_adder
//   Registered multi-digit BCD adder with a fixed one-cycle latency.
//   Adds two packed BCD operands plus a carry-in. The ripple runs from digit 0
//   upward, and the sum and the decimal carry-out are registered when
//   in_valid is high. out_valid follows in_valid one cycle later. While
//   in_valid is low, the result registers hold their previous values.
//
// Parameters
//   DIGITS        number of BCD digits per operand (1..8); W = 4*DIGITS
//
// Ports
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   in_valid      operands valid; captured on the rising edge
//   augend        packed BCD operand A, digit 0 in bits [3:0]
//   addend        packed BCD operand B, same packing
//   input_carry   decimal carry into digit 0
//   bcd_result    registered packed BCD sum
//   output_carry  registered decimal carry out of the top digit
//   out_valid     one-cycle strobe marking a new result
//   digit_error   (only with BCD_ADDER_DIGIT_CHECK_EN) registered flag set
//                 when any captured operand digit exceeds 9
//
// Configuration
//   `define BCD_ADDER_DIGIT_CHECK_EN adds the digit_error output.
// ---------------------------------------------------------------------------
module bcd_adder #(
  parameter int DIGITS = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [4*DIGITS-1:0]   augend,
  input  logic [4*DIGITS-1:0]   addend,
  input  logic                  input_carry,
  output logic [4*DIGITS-1:0]   bcd_result,
  output logic                  output_carry,
`ifdef BCD_ADDER_DIGIT_CHECK_EN
  output logic                  digit_error,
`endif
  output logic                  out_valid
);

  localparam int W = 4 * DIGITS;

  logic [W-1:0] result_d, result_q;
  logic         carry_d,  carry_q;
  logic         out_valid_q;

  // Ripple-carry decimal addition. Each digit is summed in 5 bits. If the
  // sum is above 9, adding 6 skips the six unused codes (10..15), and the
  // low nibble of that total is the decimal digit. Out-of-range operand
  // digits take the same path and are not saturated.
  always_comb begin
    logic [4:0] digit_sum;
    logic       carry_chain;
    // NOTE: every variable gets a default before the loop, so no path
    // leaves one unassigned and no latch is inferred.
    result_d    = '0;
    digit_sum   = '0;
    carry_chain = input_carry;
    for (int k = 0; k < DIGITS; k++) begin
      digit_sum = 5'(augend[4*k +: 4]) + 5'(addend[4*k +: 4]) + 5'(carry_chain);
      if (digit_sum > 5'd9) begin
        result_d[4*k +: 4] = 4'(digit_sum + 5'd6);
        carry_chain        = 1'b1;
      end else begin
        result_d[4*k +: 4] = digit_sum[3:0];
        carry_chain        = 1'b0;
      end
    end
    carry_d = carry_chain;
  end

  // NOTE: all state is updated with non-blocking assignments, so every
  // register samples the pre-edge value of its inputs. Each register has an
  // explicit reset value, and reset clears a result that is still in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q    <= '0;
      carry_q     <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= in_valid;
      if (in_valid) begin
        result_q <= result_d;
        carry_q  <= carry_d;
      end
    end
  end

  assign bcd_result   = result_q;
  assign output_carry = carry_q;
  assign out_valid    = out_valid_q;

`ifdef BCD_ADDER_DIGIT_CHECK_EN
  logic digit_error_d, digit_error_q;

  // The flag is set if any digit of either operand is a non-BCD code (10..15).
  always_comb begin
    digit_error_d = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      if ((augend[4*k +: 4] > 4'd9) || (addend[4*k +: 4] > 4'd9)) begin
        digit_error_d = 1'b1;
      end
    end
  end

  // The flag uses the same enable as the result, so it describes the
  // operation that bcd_result currently holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit_error_q <= 1'b0;
    end else if (in_valid) begin
      digit_error_q <= digit_error_d;
    end
  end

  assign digit_error = digit_error_q;
`endif

endmodule

// File: tb/tb_bcd_adder.sv
// ---------------------------------------------------------------------------
// tb_bcd_adder
//   Self-checking bench for bcd_adder. It uses two instances: DIGITS = 1 for
//   the single-digit, exhaustive, hold and out-of-range cases, and DIGITS = 2
//   for the ripple cases. Inputs change one time unit after a rising edge,
//   and outputs are sampled at that same point.
//   Define BCD_ADDER_DIGIT_CHECK_EN to also check digit_error.
// ---------------------------------------------------------------------------
module tb_bcd_adder;

  logic clk = 1'b0;
  logic rst_n;

  // DIGITS = 1 instance
  logic       in_valid1;
  logic [3:0] a1, b1;
  logic       cin1;
  logic [3:0] res1;
  logic       cout1, ov1;

  // DIGITS = 2 instance
  logic       in_valid2;
  logic [7:0] a2, b2;
  logic       cin2;
  logic [7:0] res2;
  logic       cout2, ov2;

`ifdef BCD_ADDER_DIGIT_CHECK_EN
  logic derr1, derr2;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  bcd_adder #(.DIGITS(1)) u_dut1 (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid1),
    .augend       (a1),
    .addend       (b1),
    .input_carry  (cin1),
    .bcd_result   (res1),
    .output_carry (cout1),
`ifdef BCD_ADDER_DIGIT_CHECK_EN
    .digit_error  (derr1),
`endif
    .out_valid    (ov1)
  );

  bcd_adder #(.DIGITS(2)) u_dut2 (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid2),
    .augend       (a2),
    .addend       (b2),
    .input_carry  (cin2),
    .bcd_result   (res2),
    .output_carry (cout2),
`ifdef BCD_ADDER_DIGIT_CHECK_EN
    .digit_error  (derr2),
`endif
    .out_valid    (ov2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one DIGITS=1 operation and advance to the edge that captures it.
  task automatic issue1(input logic [3:0] a, input logic [3:0] b, input logic c);
    a1 = a; b1 = b; cin1 = c; in_valid1 = 1'b1;
    step();
  endtask

  task automatic issue2(input logic [7:0] a, input logic [7:0] b, input logic c);
    a2 = a; b2 = b; cin2 = c; in_valid2 = 1'b1;
    step();
    in_valid2 = 1'b0;
  endtask

  // Directed single-digit vectors: a, b, cin, expected result, expected carry
  typedef struct {
    logic [3:0] a, b;
    logic       c;
    logic [3:0] r;
    logic       co;
  } vec1_t;

  vec1_t dir1 [5] = '{
    '{4'd3, 4'd4, 1'b0, 4'd7, 1'b0},
    '{4'd5, 4'd5, 1'b0, 4'd0, 1'b1},
    '{4'd9, 4'd9, 1'b1, 4'd9, 1'b1},
    '{4'd0, 4'd0, 1'b1, 4'd1, 1'b0},
    '{4'd9, 4'd0, 1'b1, 4'd0, 1'b1}
  };

  vec1_t b2b [4] = '{
    '{4'd1, 4'd2, 1'b0, 4'd3, 1'b0},
    '{4'd8, 4'd7, 1'b0, 4'd5, 1'b1},
    '{4'd6, 4'd3, 1'b1, 4'd0, 1'b1},
    '{4'd4, 4'd4, 1'b1, 4'd9, 1'b0}
  };

  initial begin
    rst_n = 1'b1;
    in_valid1 = 1'b1; a1 = 4'd7; b1 = 4'd2; cin1 = 1'b1;
    in_valid2 = 1'b1; a2 = 8'h45; b2 = 8'h38; cin2 = 1'b1;

    // Reset is asserted between edges while valid operands are present.
    // The outputs must clear before any clock edge arrives.
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_res", 32'(res1), 32'd0);
    check("rst_async_cout", 32'(cout1), 32'd0);
    check("rst_async_ov", 32'(ov1), 32'd0);
    check("rst_async_res2", 32'(res2), 32'd0);
    repeat (2) step();
    check("rst_hold_res", 32'(res1), 32'd0);
    check("rst_hold_ov", 32'(ov1), 32'd0);
    check("rst_hold_ov2", 32'(ov2), 32'd0);

    @(negedge clk);
    in_valid1 = 1'b0; in_valid2 = 1'b0;
    rst_n = 1'b1;
    step();
    check("post_rst_idle_ov", 32'(ov1), 32'd0);

    // First operation after reset: the result appears one cycle after issue.
    issue1(4'd3, 4'd4, 1'b0);
    in_valid1 = 1'b0;
    check("first_res", 32'(res1), 32'd7);
    check("first_ov", 32'(ov1), 32'd1);
    step();

    // Directed single-digit cases
    foreach (dir1[i]) begin
      issue1(dir1[i].a, dir1[i].b, dir1[i].c);
      in_valid1 = 1'b0;
      check($sformatf("dir%0d_res", i), 32'(res1), 32'(dir1[i].r));
      check($sformatf("dir%0d_cout", i), 32'(cout1), 32'(dir1[i].co));
      check($sformatf("dir%0d_ov", i), 32'(ov1), 32'd1);
    end

    // Exhaustive single-digit sweep, issued back-to-back
    for (int a = 0; a < 10; a++) begin
      for (int b = 0; b < 10; b++) begin
        for (int c = 0; c < 2; c++) begin
          issue1(4'(a), 4'(b), 1'(c));
          check($sformatf("ex_%0d_%0d_%0d_res", a, b, c), 32'(res1), 32'((a + b + c) % 10));
          check($sformatf("ex_%0d_%0d_%0d_cout", a, b, c), 32'(cout1), 32'((a + b + c) >= 10));
        end
      end
    end
    in_valid1 = 1'b0;

    // Hold: the operands change while in_valid is low, and the result must not move.
    step();
    issue1(4'd2, 4'd2, 1'b0);
    in_valid1 = 1'b0;
    check("hold_issue_res", 32'(res1), 32'd4);
    check("hold_issue_ov", 32'(ov1), 32'd1);
    for (int i = 0; i < 3; i++) begin
      a1 = 4'(7 + i); b1 = 4'd8; cin1 = 1'b1;
      step();
      check($sformatf("hold%0d_res", i), 32'(res1), 32'd4);
      check($sformatf("hold%0d_cout", i), 32'(cout1), 32'd0);
      check($sformatf("hold%0d_ov", i), 32'(ov1), 32'd0);
    end

    // Back-to-back: four consecutive operations give four consecutive results.
    foreach (b2b[i]) begin
      issue1(b2b[i].a, b2b[i].b, b2b[i].c);
      check($sformatf("b2b%0d_res", i), 32'(res1), 32'(b2b[i].r));
      check($sformatf("b2b%0d_cout", i), 32'(cout1), 32'(b2b[i].co));
      check($sformatf("b2b%0d_ov", i), 32'(ov1), 32'd1);
    end
    in_valid1 = 1'b0;
    step();
    check("b2b_end_ov", 32'(ov1), 32'd0);

    // Out-of-range digits: 15+15+1 = 31, and (31+6)[3:0] = 5 with carry 1.
    issue1(4'd15, 4'd15, 1'b1);
    in_valid1 = 1'b0;
    check("oor_res", 32'(res1), 32'd5);
    check("oor_cout", 32'(cout1), 32'd1);
`ifdef BCD_ADDER_DIGIT_CHECK_EN
    check("oor_derr", 32'(derr1), 32'd1);
    a1 = 4'd0; b1 = 4'd0;
    step();
    check("oor_derr_hold", 32'(derr1), 32'd1);
`endif
    issue1(4'd9, 4'd9, 1'b0);
    in_valid1 = 1'b0;
    check("max_res", 32'(res1), 32'd8);
    check("max_cout", 32'(cout1), 32'd1);
`ifdef BCD_ADDER_DIGIT_CHECK_EN
    check("max_derr", 32'(derr1), 32'd0);
`endif

    // Two-digit ripple
    issue2(8'h99, 8'h01, 1'b0);
    check("d2_99_01_res", 32'(res2), 32'h00);
    check("d2_99_01_cout", 32'(cout2), 32'd1);
    check("d2_99_01_ov", 32'(ov2), 32'd1);
    issue2(8'h45, 8'h38, 1'b1);
    check("d2_45_38_res", 32'(res2), 32'h84);
    check("d2_45_38_cout", 32'(cout2), 32'd0);
    issue2(8'h50, 8'h50, 1'b0);
    check("d2_50_50_res", 32'(res2), 32'h00);
    check("d2_50_50_cout", 32'(cout2), 32'd1);
    // Upper digit 15+0 = 15 becomes (15+6)[3:0] = 5 with carry 1, giving 0x50.
    issue2(8'hF0, 8'h00, 1'b0);
    check("d2_f0_res", 32'(res2), 32'h50);
    check("d2_f0_cout", 32'(cout2), 32'd1);
`ifdef BCD_ADDER_DIGIT_CHECK_EN
    check("d2_f0_derr", 32'(derr2), 32'd1);
`endif
    check("d2_idle_ov", 32'(ov2), 32'd1);
    step();
    check("d2_after_ov", 32'(ov2), 32'd0);
    check("d2_after_res", 32'(res2), 32'h50);

    // Reset in mid-operation: the valid operation is still being presented,
    // and reset must discard the stored result.
    issue1(4'd3, 4'd4, 1'b0);
    check("mid_pre_res", 32'(res1), 32'd7);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_res", 32'(res1), 32'd0);
    check("mid_rst_ov", 32'(ov1), 32'd0);
    check("mid_rst_res2", 32'(res2), 32'd0);
    check("mid_rst_cout2", 32'(cout2), 32'd0);
    @(negedge clk);
    in_valid1 = 1'b0;
    rst_n = 1'b1;
    step();
    check("mid_post_ov", 32'(ov1), 32'd0);
    check("mid_post_res", 32'(res1), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
